// File: rtl/load_store_unit.sv
// load_store_unit: sequences one RV32I load/store onto the single-port data memory, returning an extended load result with a done/err handshake.
module load_store_unit #(
  parameter int DM_ADDR_W  = 16,
  parameter int RD_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [2:0]           funct3,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic                 done,
  output logic                 err,
  output logic                 busy,
  output logic [DM_ADDR_W-1:0] dm_addr,
  output logic [3:0]           dm_byte_en,
  output logic [31:0]          dm_w_data,
  output logic                 dm_w_en,
  input  logic [31:0]          dm_r_data
);
  localparam int CW = $clog2(RD_LATENCY + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, ERR} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] f3;
  logic [1:0] lane;
  logic st;
  logic bad_f3, misalign, out_of_range, illegal;
  logic [3:0] st_be;
  logic [31:0] st_wd, ext;
  logic [7:0] b;
  logic [15:0] h;
  assign bad_f3 = is_store ? (funct3[2] | (funct3[1:0] == 2'b11))
                           : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
  assign misalign = (funct3[1:0] == 2'b01 && addr[0]) || (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
  assign out_of_range = |(addr >> (DM_ADDR_W + 2));
  assign illegal = bad_f3 | misalign | out_of_range;
  assign st_be = funct3[1] ? 4'hf : funct3[0] ? (addr[1] ? 4'hc : 4'h3) : 4'b0001 << addr[1:0];
  assign st_wd = funct3[1] ? wdata : funct3[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
  assign b = dm_r_data[8*lane +: 8];
  assign h = lane[1] ? dm_r_data[31:16] : dm_r_data[15:0];
  assign ext = f3 == 3'b000 ? {{24{b[7]}}, b} :
               f3 == 3'b100 ? {24'b0, b} :
               f3 == 3'b001 ? {{16{h[15]}}, h} :
               f3 == 3'b101 ? {16'b0, h} : dm_r_data;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      f3         <= '0;
      lane       <= '0;
      st         <= 1'b0;
      rdata      <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
      dm_addr    <= '0;
      dm_byte_en <= '0;
      dm_w_data  <= '0;
      dm_w_en    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          f3   <= funct3;
          lane <= addr[1:0];
          st   <= is_store;
          busy <= 1'b1;
          if (illegal) state <= ERR;
          else begin
            state      <= ISSUE;
            dm_addr    <= addr[DM_ADDR_W+1:2];
            dm_byte_en <= is_store ? st_be : 4'hf;
            dm_w_data  <= is_store ? st_wd : 32'h0;
            dm_w_en    <= is_store;
          end
        end
        ISSUE: begin
          dm_w_en <= 1'b0;
          cnt     <= CW'(RD_LATENCY - 1);
          state   <= st ? DONE : WAIT;
          done    <= st;
        end
        WAIT: if (cnt == '0) begin
          rdata <= ext;
          state <= DONE;
          done  <= 1'b1;
        end else cnt <= cnt - 1'b1;
        ERR: begin
          state <= DONE;
          done  <= 1'b1;
          err   <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: table-driven check of load_store_unit against a 2-cycle-latency memory model, plus busy/reset sequences.
module tb_load_store_unit;
  logic clk = 0, rst = 0, start = 0, is_store = 0;
  logic [2:0] funct3 = 0;
  logic [31:0] addr = 0, wdata = 0, rdata, dm_w_data, dm_r_data;
  logic done, err, busy, dm_w_en;
  logic [15:0] dm_addr;
  logic [3:0] dm_byte_en;
  logic pl_en = 0;
  logic [7:0] pl_a = 0, a1;
  logic [31:0] pl_d = 0;
  logic [31:0] mem [256];
  int errors = 0, checks = 0;

  load_store_unit dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .dm_addr(dm_addr), .dm_byte_en(dm_byte_en), .dm_w_data(dm_w_data),
    .dm_w_en(dm_w_en), .dm_r_data(dm_r_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_en) mem[pl_a] <= pl_d;
    else if (dm_w_en)
      for (int i = 0; i < 4; i++) if (dm_byte_en[i]) mem[dm_addr[7:0]][8*i +: 8] <= dm_w_data[8*i +: 8];
    a1 <= dm_addr[7:0];
    dm_r_data <= mem[a1];
  end

  typedef struct {
    logic st; logic [2:0] f3; logic [31:0] a, wd, rd; logic er; logic [3:0] be; logic [31:0] dwd; int lat;
  } vec_t;
  vec_t v [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic op(input vec_t x, input int id);
    int cyc;
    logic wen;
    logic [15:0] da;
    logic [3:0] be;
    logic [31:0] dwd;
    @(negedge clk);
    start = 1; is_store = x.st; funct3 = x.f3; addr = x.a; wdata = x.wd;
    @(negedge clk);
    start = 0; cyc = 1;
    da = dm_addr; be = dm_byte_en; dwd = dm_w_data; wen = dm_w_en;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      wen |= dm_w_en;
    end
    chk($sformatf("v%0d latency", id), cyc, x.lat);
    chk($sformatf("v%0d err", id), err, x.er);
    chk($sformatf("v%0d rdata", id), rdata, x.rd);
    chk($sformatf("v%0d w_en", id), wen, x.st && !x.er);
    if (!x.er) begin
      chk($sformatf("v%0d dm_addr", id), da, x.a[17:2]);
      chk($sformatf("v%0d byte_en", id), be, x.be);
      chk($sformatf("v%0d w_data", id), dwd, x.dwd);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1; pl_a = a; pl_d = d;
    @(negedge clk);
    pl_en = 0;
  endtask

  initial begin
    int dcnt;
    v[0]  = '{0, 3'b000, 32'h13, 0, 32'hFFFFFF80, 0, 4'hf, 0, 4};
    v[1]  = '{0, 3'b100, 32'h13, 0, 32'h00000080, 0, 4'hf, 0, 4};
    v[2]  = '{0, 3'b001, 32'h12, 0, 32'hFFFF80FF, 0, 4'hf, 0, 4};
    v[3]  = '{0, 3'b101, 32'h10, 0, 32'h00007F01, 0, 4'hf, 0, 4};
    v[4]  = '{0, 3'b000, 32'h11, 0, 32'h0000007F, 0, 4'hf, 0, 4};
    v[5]  = '{1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0000007F, 0, 4'hf, 32'hDEADBEEF, 2};
    v[6]  = '{0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0, 4'hf, 0, 4};
    v[7]  = '{1, 3'b000, 32'h0E, 32'h000000A5, 32'hDEADBEEF, 0, 4'b0100, 32'hA5A5A5A5, 2};
    v[8]  = '{0, 3'b010, 32'h0C, 0, 32'h11A53344, 0, 4'hf, 0, 4};
    v[9]  = '{1, 3'b001, 32'h16, 32'h1234CAFE, 32'h11A53344, 0, 4'b1100, 32'hCAFECAFE, 2};
    v[10] = '{0, 3'b101, 32'h16, 0, 32'h0000CAFE, 0, 4'hf, 0, 4};
    v[11] = '{0, 3'b001, 32'h16, 0, 32'hFFFFCAFE, 0, 4'hf, 0, 4};
    v[12] = '{0, 3'b001, 32'h11, 0, 32'hFFFFCAFE, 1, 4'h0, 0, 2};
    v[13] = '{1, 3'b010, 32'h12, 32'h55, 32'hFFFFCAFE, 1, 4'h0, 0, 2};
    v[14] = '{1, 3'b000, 32'h40000, 32'h55, 32'hFFFFCAFE, 1, 4'h0, 0, 2};
    v[15] = '{0, 3'b011, 32'h0, 0, 32'hFFFFCAFE, 1, 4'h0, 0, 2};
    v[16] = '{1, 3'b100, 32'h0, 32'h55, 32'hFFFFCAFE, 1, 4'h0, 0, 2};

    preload(8'd3, 32'h11223344);
    preload(8'd4, 32'h80FF7F01);
    preload(8'd5, 32'h0000F00D);
    chk("reset rdata", rdata, 0);
    chk("reset busy", busy, 0);
    chk("reset done/err", {done, err}, 0);
    chk("reset dm", {dm_addr, dm_byte_en, dm_w_en}, 0);
    chk("reset w_data", dm_w_data, 0);
    @(negedge clk);
    rst = 1;

    for (int i = 0; i < 17; i++) op(v[i], i);

    // load with ignored start pulses (a would-be store to 0x14) in cycles 1..3
    @(negedge clk);
    start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h10;
    dcnt = 0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      chk($sformatf("busy c%0d", c), busy, (c <= 4));
      chk($sformatf("done c%0d", c), done, (c == 4));
      dcnt += int'(done);
      start = (c <= 3); is_store = 1; addr = 32'h14; wdata = 0;
    end
    start = 0;
    chk("busy-start done count", dcnt, 1);
    chk("busy-start rdata", rdata, 32'hDEADBEEF);

    // reset in WAIT
    @(negedge clk);
    start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h10;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    rst = 0;
    #1;
    chk("wait-rst busy", busy, 0);
    chk("wait-rst rdata", rdata, 0);
    chk("wait-rst dm", {dm_addr, dm_byte_en}, 0);
    chk("wait-rst done", done, 0);
    @(negedge clk);
    rst = 1;
    dcnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      dcnt += int'(done);
    end
    chk("wait-rst no done", dcnt, 0);

    // reset in store ISSUE: strobe drops immediately and word 5 stays intact
    @(negedge clk);
    start = 1; is_store = 1; funct3 = 3'b010; addr = 32'h14; wdata = 32'hFFFFFFFF;
    @(negedge clk);
    start = 0;
    chk("issue w_en", dm_w_en, 1);
    rst = 0;
    #1;
    chk("issue-rst w_en", dm_w_en, 0);
    @(negedge clk);
    rst = 1;

    op('{0, 3'b010, 32'h14, 0, 32'hCAFEF00D, 0, 4'hf, 0, 4}, 17);
    op('{0, 3'b010, 32'h10, 0, 32'hDEADBEEF, 0, 4'hf, 0, 4}, 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
